mem_access_master: RTL
======================

# mem_access_master

Initiator-side sequencer for the accumulator processor's unified 16-bit instruction/data memory. It accepts single-word write and 1–4 word read requests from the multi-cycle control unit over a valid/ready handshake. It drives the memory's address, read-enable, write-enable and write-data lines, and returns read data over a valid/ready response channel. The block is the only master on the memory port.

## Interface
- ADDR_W, 13, memory address width
- DATA_W, 16, memory word width
- MEM_DEPTH, 128, number of implemented words; valid addresses are 0..MEM_DEPTH-1
- READ_WAIT, 1, cycles the address and read-enable are held before `mem_data_out` is sampled (≥1)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start word address
- req_wdata  in  DATA_W  write data
- req_len  in  2  read burst length minus 1 (0..3); ignored for writes
- rsp_valid  out  1  read word available
- rsp_ready  in  1  consumer accepts the read word
- rsp_data  out  DATA_W  read word
- rsp_last  out  1  final word of the burst
- wr_done  out  1  one-cycle pulse: write committed at the end of this cycle
- err  out  1  one-cycle pulse: request rejected because `req_addr` ≥ MEM_DEPTH
- mem_address  out  ADDR_W  memory address
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory read data

## Operation
- States: IDLE, WRITE, RD_WAIT, RD_RESP.
- `req_ready` is 1 only in IDLE. A request is accepted on a rising edge with `req_valid && req_ready`.
- Address check at acceptance:
  - If `req_addr` ≥ MEM_DEPTH, the block stays in IDLE and pulses `err` for one cycle.
  - No memory enable is asserted.
  - No response is produced.
- Write path:
  - IDLE→WRITE. Latches address and data.
  - In WRITE: `mem_write_en`=1, `mem_address`/`mem_data_in` driven from the latches, `wr_done`=1.
  - WRITE→IDLE unconditionally after one cycle.
- Read path:
  - IDLE→RD_WAIT. Latches address and loads `remaining`=`req_len`.
  - In RD_WAIT: `mem_read_en`=1 and `mem_address` is stable. A wait counter loaded with READ_WAIT counts down. On the edge where it expires, `mem_data_out` is captured into `rsp_data` and the state moves to RD_RESP.
  - In RD_RESP: `rsp_valid`=1, `mem_read_en`=0, and `rsp_last`=(`remaining`==0). `rsp_data` is held stable until the handshake.
  - On `rsp_valid && rsp_ready`:
    - If `remaining`==0, go to IDLE.
    - Otherwise decrement `remaining`, set address to (address+1) mod MEM_DEPTH, and go to RD_WAIT.
- Address arithmetic: the increment wraps, so MEM_DEPTH-1 is followed by 0. Upper address bits stay 0 after the wrap.
- `mem_write_en` and `mem_read_en` are never high in the same cycle.

## Timing
- Reset values: state IDLE, `req_ready`=1, and every other output 0 (`rsp_valid`, `rsp_data`, `rsp_last`, `wr_done`, `err`, `mem_address`, `mem_read_en`, `mem_write_en`, `mem_data_in`).
- Write latency: accepted at edge N; `mem_write_en` high during cycle N→N+1; memory commits at edge N+1; `req_ready` returns in cycle N+1.
- Read latency (READ_WAIT=1, `rsp_ready`=1):
  - Accepted at edge N.
  - `mem_read_en` high in cycle N→N+1.
  - Data captured at edge N+1.
  - `rsp_valid` high in cycle N+1→N+2.
  - Handshake at edge N+2.
- Read timing in general:
  - First word appears READ_WAIT cycles after acceptance.
  - Each additional word adds READ_WAIT+1 cycles when `rsp_ready` is held high.
  - A 4-word burst with READ_WAIT=1 completes its last handshake at edge N+8.
- Backpressure:
  - `rsp_ready`=0 holds RD_RESP indefinitely, with `rsp_data` and `rsp_last` stable.
  - `rsp_ready` asserted outside RD_RESP is ignored.
- Request inputs are don't-care outside the acceptance edge. A held `req_valid` is accepted again on the first edge back in IDLE.
- Asynchronous reset mid-operation:
  - All outputs go to their reset values immediately; `mem_write_en` and `mem_read_en` drop without waiting for a clock edge.
  - Any partial burst is discarded and no `rsp_last` is issued.
  - `req_ready`=1 from the first cycle after reset is released.

## Test plan
- Write then read: write 0xBEEF to address 50 → one `mem_write_en` cycle with `mem_address`=50 and `wr_done` pulse. Then a single read of 50 with `rsp_ready`=1 → `rsp_data`=0xBEEF and `rsp_last`=1 at edge N+2.
- Burst read, addresses 100..103 preloaded 0x0001..0x0004, `req_len`=3, `rsp_ready`=1 → four responses 0x0001..0x0004 at READ_WAIT+1-cycle spacing; `rsp_last` only on the fourth; `req_ready` low throughout.
- Wrap: burst of 3 starting at 126 → `mem_address` sequence 126, 127, 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during a 2-word burst → `rsp_data` and `rsp_valid` constant; no second `mem_read_en` until the handshake.
- Error: `req_addr`=200 → single `err` pulse, no memory enables, `req_ready` stays 1.
- Reset mid-burst: drop `rsp_n` low during word 2 of 4 → all outputs 0 asynchronously; after release the block is IDLE with `req_ready`=1 and a new single read completes normally.

Source files
------------

// File: rtl/mem_access_master.sv
// mem_access_master
//   Sole master on the accumulator processor's unified 16-bit memory port.
//   It takes single-word writes and 1..4 word read bursts from the control
//   unit, drives the memory lines, and returns read words on a valid/ready
//   response channel.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_addr,           request: direction, start address,
//   req_wdata, req_len             write word, burst length-1 (reads)
//   rsp_valid/rsp_ready            read response handshake
//   rsp_data, rsp_last             read word, final word of burst
//   wr_done                        pulse: write commits at end of this cycle
//   err                            pulse: request rejected (address too high)
//   mem_address, mem_read_en,      memory port (outputs)
//   mem_write_en, mem_data_in
//   mem_data_out                   memory read data (input)
module mem_access_master #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 128,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_RESP} state_t;

  localparam int                WAIT_W    = $clog2(READ_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = 32'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              addr_ok;

  assign addr_ok = 32'(req_addr) < DEPTH_U;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else if (req_write) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = WRITE;
          end else begin
            addr_d      = req_addr;
            remaining_d = req_len;
            wait_d      = WAIT_INIT;
            state_d     = RD_WAIT;
          end
        end
      end
      WRITE: state_d = IDLE;
      RD_WAIT: begin
        // The counter holds the cycles still to wait including the current
        // one, so a value of 1 marks the sampling edge.
        if (wait_q <= WAIT_W'(1)) begin
          rdata_d = mem_data_out;
          state_d = RD_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RD_RESP: begin
        if (rsp_ready) begin
          if (remaining_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - 2'd1;
            // Wrap inside the implemented range, not the full address width.
            addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            wait_d      = WAIT_INIT;
            state_d     = RD_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables decode straight from the state register so the asynchronous
  // reset removes them immediately, and only one can be high at a time.
  assign req_ready    = (state_q == IDLE);
  assign mem_write_en = (state_q == WRITE);
  assign wr_done      = (state_q == WRITE);
  assign mem_read_en  = (state_q == RD_WAIT);
  assign rsp_valid    = (state_q == RD_RESP);
  assign rsp_last     = (state_q == RD_RESP) && (remaining_q == 2'd0);
  assign rsp_data     = rdata_q;
  assign mem_address  = addr_q;
  assign mem_data_in  = wdata_q;
  assign err          = err_q;

endmodule
